// File: rtl/sqrt_seq_ctrl_if.sv
// Client-facing bundle for the square-root sequencer.
// master: client side (drives req*/rad*, sees grants and results).
// slave : sequencer side (owns gnt*, busy, done, owner, root, rem).
interface sqrt_seq_ctrl_if #(parameter int WIDTH = 16);
  logic                 req0;
  logic                 req1;
  logic [WIDTH-1:0]     rad0;
  logic [WIDTH-1:0]     rad1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 busy;
  logic                 done;
  logic                 owner;
  logic [WIDTH/2-1:0]   root;
  logic [WIDTH/2:0]     rem;

  modport master (
    output req0, req1, rad0, rad1,
    input  gnt0, gnt1, busy, done, owner, root, rem
  );

  modport slave (
    input  req0, req1, rad0, rad1,
    output gnt0, gnt1, busy, done, owner, root, rem
  );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// Two-requester sequencer/arbiter for an iterative restoring square root.
// Accepts a radicand from client 0 or 1 in IDLE, runs WIDTH/2 steps (one
// per clock), then pulses done with root = floor(sqrt(rad)) and
// rem = rad - root^2.
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-low reset
//   bus  - sqrt_seq_ctrl_if.slave: req0/rad0, req1/rad1 in;
//          gnt0, gnt1, busy, done, owner, root, rem out
// Build option: define SQRT_SEQ_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise client 0 has fixed priority.
module sqrt_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          clr,
  sqrt_seq_ctrl_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [N-1:0]     root_q;
  logic [N:0]       rem_q;
  logic [KW-1:0]    k;
  logic             owner_q;
  logic             gnt0_q, gnt1_q;
  logic             accept;
  logic             win;
  logic [N+2:0]     t;
  logic             t_ge;

`ifdef SQRT_SEQ_ROUND_ROBIN_EN
  logic             last_owner;
  // On a tie the client that did not win last time goes first.
  assign win = bus.req1 & (~bus.req0 | ~last_owner);
`else
  assign win = bus.req1 & ~bus.req0;
`endif

  assign accept = (state == IDLE) & (bus.req0 | bus.req1);

  // Trial subtraction for one restoring step.
  assign t = {rem_q, shreg[WIDTH-1 -: 2]} - {1'b0, root_q, 2'b01};
  // A non-negative difference always fits in N+1 bits, so both top bits
  // are zero exactly when the trial succeeds.
  assign t_ge = (t[N+2:N+1] == 2'b00);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ITER;
      ITER:    if (k == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      shreg   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      k       <= '0;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      if (accept) begin
        shreg   <= win ? bus.rad1 : bus.rad0;
        root_q  <= '0;
        rem_q   <= '0;
        k       <= KW'(N - 1);
        owner_q <= win;
        gnt0_q  <= ~win;
        gnt1_q  <= win;
      end else if (state == ITER) begin
        if (t_ge) begin
          rem_q  <= t[N:0];
          root_q <= {root_q[N-2:0], 1'b1};
        end else begin
          rem_q  <= {rem_q[N-2:0], shreg[WIDTH-1 -: 2]};
          root_q <= {root_q[N-2:0], 1'b0};
        end
        shreg <= shreg << 2;
        if (k != '0) k <= k - KW'(1);
      end
    end
  end

`ifdef SQRT_SEQ_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                last_owner <= 1'b1;
    else if (state == DONE)  last_owner <= owner_q;
  end
`endif

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.owner = owner_q;
  assign bus.root  = root_q;
  assign bus.rem   = rem_q;
endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Bench for sqrt_seq_ctrl (WIDTH = 16). Reference results come from plain
// integer square root; arbitration expectations follow the selected build
// (SQRT_SEQ_ROUND_ROBIN_EN defined or not).
module tb_sqrt_seq_ctrl;
  localparam int W = 16;
  localparam int N = W / 2;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   m_last = 1;  // model of last served client (tie breaking)

  sqrt_seq_ctrl_if #(.WIDTH(W)) bus ();

  sqrt_seq_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int arb(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef SQRT_SEQ_ROUND_ROBIN_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"},  32'(bus.gnt0),  0);
    check({tag, "_gnt1"},  32'(bus.gnt1),  0);
    check({tag, "_busy"},  32'(bus.busy),  0);
    check({tag, "_done"},  32'(bus.done),  0);
    check({tag, "_owner"}, 32'(bus.owner), 0);
    check({tag, "_root"},  32'(bus.root),  0);
    check({tag, "_rem"},   32'(bus.rem),   0);
  endtask

  // Waits (bounded) for a grant; returns granting client and cycle count.
  task automatic wait_gnt(input string tag, output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt0 || bus.gnt1) begin
        who = bus.gnt1 ? 1 : 0;
        break;
      end
    end
    if (who < 0) check({tag, "_gnt_timeout"}, 0, 1);
  endtask

  // Called at the negedge where gnt was seen; follows through to IDLE.
  task automatic finish_op(input string tag, input int exp_owner, input int rad);
    int lat = 0;
    int er  = isqrt(rad);
    int em  = rad - er * er;
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({tag, "_gnt_pulse"}, 32'(bus.gnt0 | bus.gnt1), 0);
        check({tag, "_busy"}, 32'(bus.busy), 1);
      end
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    check({tag, "_latency"}, got ? lat : -1, N);
    check({tag, "_root"},  32'(bus.root),  er);
    check({tag, "_rem"},   32'(bus.rem),   em);
    check({tag, "_owner"}, 32'(bus.owner), exp_owner);
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(bus.done), 0);
    check({tag, "_busy_drop"}, 32'(bus.busy), 0);
    check({tag, "_root_hold"}, 32'(bus.root), er);
    m_last = exp_owner;
  endtask

  task automatic single_op(input string tag, input int c, input int rad);
    int who, cyc;
    if (c == 0) begin bus.req0 = 1'b1; bus.rad0 = W'(rad); end
    else        begin bus.req1 = 1'b1; bus.rad1 = W'(rad); end
    wait_gnt(tag, who, cyc);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check({tag, "_winner"}, who, c);
    finish_op(tag, c, rad);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    m_last = 1;
  endtask

  initial begin
    int who, cyc, ew, seen, r0, r1;
    clr = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.rad0 = '0;   bus.rad1 = '0;

    // Reset held with a live request: no grant, outputs zero.
    bus.req0 = 1'b1;
    bus.rad0 = W'(144);
    repeat (3) begin
      @(negedge clk);
      check_all_zero("rst");
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    single_op("r144", 0, 144);
    single_op("r65535", 0, 65535);
    single_op("r0", 0, 0);
    single_op("r2", 0, 2);

    // Simultaneous requests right after reset.
    do_reset();
    bus.rad0 = W'(100); bus.rad1 = W'(50);
    bus.req0 = 1'b1;    bus.req1 = 1'b1;
    ew = arb(1, 1);
    wait_gnt("tie_a", who, cyc);
    check("tie_a_winner", who, ew);
    if (who == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    finish_op("tie_a", ew, ew ? 50 : 100);
    ew = arb(bus.req0, bus.req1);
    wait_gnt("tie_b", who, cyc);
    check("tie_b_winner", who, ew);
    check("tie_b_first_idle_edge", cyc, 1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    finish_op("tie_b", ew, ew ? 50 : 100);

    // Random single-client operations.
    for (int i = 0; i < 8; i++)
      single_op("rand", int'($urandom_range(0, 1)), int'($urandom & 32'hFFFF));

    // Reset in the 4th iteration cycle aborts without a done pulse.
    bus.req0 = 1'b1;
    bus.rad0 = W'(60000);
    wait_gnt("abort", who, cyc);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    clr = 1'b1;
    m_last = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    check("abort_no_done", seen, 0);
    single_op("r49", 1, 49);

    // Both clients hold requests continuously.
    r0 = int'($urandom & 32'hFFFF);
    r1 = int'($urandom & 32'hFFFF);
    bus.rad0 = W'(r0); bus.rad1 = W'(r1);
    bus.req0 = 1'b1;   bus.req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ew = arb(1, 1);
      wait_gnt("hold", who, cyc);
      check("hold_winner", who, ew);
      finish_op("hold", ew, ew ? r1 : r0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sqrt_seq_ctrl.md
# sqrt_seq_ctrl

Two-requester sequencer and arbiter for the iterative square-root unit. It accepts a radicand from one of two client ports and steps an internal restoring square-root datapath once per clock. It then returns the integer root and remainder with a one-cycle done pulse. It sits between the client logic and the flip-flop based root/remainder registers, and owns their load and step enables.

## Interface
- WIDTH, 16, radicand width; must be even and ≥ 4; N = WIDTH/2 iterations
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-low reset
- req0  input  1  request from client 0; held high until gnt0 is seen
- rad0  input  WIDTH  radicand from client 0; stable while req0 high
- req1  input  1  request from client 1
- rad1  input  WIDTH  radicand from client 1
- gnt0  output  1  one-cycle pulse: client 0 request accepted
- gnt1  output  1  one-cycle pulse: client 1 request accepted
- busy  output  1  high from accept through the DONE cycle
- done  output  1  one-cycle pulse: root/rem valid
- owner  output  1  client index of the current/last operation
- root  output  WIDTH/2  integer floor(sqrt(radicand))
- rem  output  WIDTH/2+1  radicand − root²

## Operation
- States:
  - IDLE: no operation in progress.
  - ITER: iterations running; the step counter k counts N−1 down to 0.
  - DONE: result presented for one cycle.
- IDLE:
  - Sampled at each rising edge.
  - If any req is high, the arbiter picks a winner. Then:
    - load rad_w into the shift register;
    - clear root/rem;
    - k = N−1;
    - owner = w;
    - gnt_w = 1 for the next cycle;
    - next state is ITER.
- Arbitration (macro defined): round-robin. If both requests are high, the client that is not last_owner wins. last_owner resets to 1, so client 0 wins the first tie.
- ITER, per edge:
  - t = {rem, shreg[WIDTH−1:WIDTH−2]} − {root, 2'b01}, computed WIDTH/2+3 bits wide.
  - If t ≥ 0: rem = t and root = {root, 1}.
  - Otherwise: rem = {rem, top two bits} and root = {root, 0}.
  - shreg shifts left by 2.
  - If k == 0, go to DONE; otherwise decrement k.
- DONE:
  - done = 1 for exactly one cycle.
  - last_owner = owner.
  - Next state is IDLE.
- root, rem and owner hold their values until the next accept.
- Requests present during ITER/DONE are ignored. A req still high in IDLE after its gnt is treated as a new request; clients must drop req the cycle after gnt.
- Reset (clr low, any state, including mid-ITER):
  - Immediately forces state IDLE.
  - Clears gnt0, gnt1, busy, done, owner, root, rem, shreg and k.
  - Sets last_owner = 1.
  - No done pulse is produced for the aborted operation.

## Timing
- Edge E0 accepts a request in IDLE. After E0: gnt_w = 1, busy = 1, state ITER.
- Edges E1..EN perform the N steps. gnt_w falls after E1.
- After EN: done = 1 and root/rem are valid. After EN+1: done = 0, busy = 0, state IDLE.
- Latency: done asserts N cycles after gnt (8 for WIDTH = 16).
- Throughput: earliest next accept is at edge EN+2, so one operation per N+2 cycles.
- Reset values: every output is 0.

## Configuration
- Macro: SQRT_SEQ_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, req0 always beats req1. The last_owner register is not built; owner still reports the winner.

## Test plan
- Reset: hold clr low with req0 = 1 → gnt0, gnt1, busy, done, owner, root and rem are all 0. No gnt is issued while clr is low.
- WIDTH = 16, req0 with rad0 = 144 →
  - gnt0 pulses one cycle after the accept edge;
  - done pulses exactly 8 cycles after gnt0;
  - root = 12, rem = 0, owner = 0.
- Edge values:
  - rad0 = 65535 → root = 255, rem = 510.
  - rad0 = 0 → root = 0, rem = 0.
  - rad0 = 2 → root = 1, rem = 1.
- Tie handling: after reset, req0 and req1 rise together with rad0 = 100, rad1 = 50. Both requesters hold req until their own gnt.
  - Macro defined: client 0 is served first (root = 10, rem = 0, owner = 0). gnt1 follows at the first IDLE edge after done; result is root = 7, rem = 1, owner = 1.
  - Macro undefined with both requests held continuously: client 0 is served every time.
- Mid-operation reset: pull clr low during the 4th ITER cycle →
  - all outputs go to 0 immediately and no done pulse appears;
  - after clr returns high, req1 with rad1 = 49 gives root = 7, rem = 0.
